// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low segment codes for hex 0..F,
// the all-off blank code, and the capture FSM state type.
package seg7_pkg;

  localparam int NUM_CODES = 16;

  // Index is the hex value; bit 0 is segment a, bit 6 is segment g, 0 = lit.
  localparam logic [6:0] SEG_CODES [NUM_CODES] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_HOLD   = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to nibble decoder; zero latency, no flow control.
// Unknown patterns report err, the all-off pattern reports blank; hex is 0 in both cases.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [3:0] o_hex,
  output logic       o_blank,
  output logic       o_err
);

  always_comb begin
    o_hex   = 4'h0;
    o_blank = 1'b0;
    o_err   = 1'b1;
    if (i_code == SEG_BLANK) begin
      o_blank = 1'b1;
      o_err   = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CODES; i++) begin
        if (i_code == SEG_CODES[i]) begin
          o_hex = 4'(i);
          o_err = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Debounces a multiplexed 7-segment bus and latches one decoded nibble per digit.
// Outputs update STABLE_CNT+1 cycles after the bus settles; passive observer, no backpressure.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [7:0]              i_leds,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  output logic [4*NUM_DIGITS-1:0] o_hex,
  output logic [NUM_DIGITS-1:0]   o_dp,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [NUM_DIGITS-1:0]   o_err,
  output logic                    o_frame_valid,
  output logic                    o_scan_err
);

  localparam int SW = 8 + NUM_DIGITS;
  localparam int CW = $clog2(STABLE_CNT);
  // Capture fires on the comparison that would bring the count to STABLE_CNT-1.
  localparam logic [CW-1:0] CAP_CNT = CW'(STABLE_CNT - 2);

  logic [SW-1:0]           sample_q, sample_d, prev_q, prev_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d, blank_q, blank_d, err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_nxt;
  logic                    frame_q, frame_d, scan_q, scan_d;

  logic [NUM_DIGITS-1:0]   smp_en;
  logic [6:0]              smp_seg;
  logic                    smp_dp;
  logic                    same, capture, en_any, en_multi;
  logic [3:0]              dec_hex;
  logic                    dec_blank, dec_err;

  assign sample_d = {i_leds, i_digit_en};
  assign prev_d   = sample_q;
  assign smp_en   = sample_q[NUM_DIGITS-1:0];
  assign smp_seg  = sample_q[NUM_DIGITS +: 7];
  assign smp_dp   = sample_q[NUM_DIGITS + 7];
  assign same     = (sample_q == prev_q);

  seg7_pattern_decode u_decode (
    .i_code  (smp_seg),
    .o_hex   (dec_hex),
    .o_blank (dec_blank),
    .o_err   (dec_err)
  );

  always_comb begin
    en_any   = 1'b0;
    en_multi = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (smp_en[i]) begin
        if (en_any) en_multi = 1'b1;
        en_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    capture  = 1'b0;
    hex_d    = hex_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    seen_nxt = seen_q;
    frame_d  = 1'b0;
    scan_d   = 1'b0;

    case (state_q)
      ST_SETTLE: begin
        if (!same) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CAP_CNT) begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (!same) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase

    if (capture) begin
      if (!en_any || en_multi) begin
        scan_d = 1'b1;
      end else begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (smp_en[i]) begin
            hex_d[4*i +: 4] = dec_hex;
            dp_d[i]         = smp_dp;
            blank_d[i]      = dec_blank;
            err_d[i]        = dec_err;
            seen_nxt[i]     = 1'b1;
          end
        end
        // A completed frame restarts collection immediately.
        if (&seen_nxt) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_nxt;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      state_q  <= ST_SETTLE;
      hex_q    <= '0;
      dp_q     <= '0;
      blank_q  <= '1;
      err_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      scan_q   <= 1'b0;
    end else begin
      sample_q <= sample_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      hex_q    <= hex_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      scan_q   <= scan_d;
    end
  end

  assign o_hex         = hex_q;
  assign o_dp          = dp_q;
  assign o_blank       = blank_q;
  assign o_err         = err_q;
  assign o_frame_valid = frame_q;
  assign o_scan_err    = scan_q;

endmodule
